router_fifo: RTL and testbench
==============================

ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of storage words.
REQ-002 Parameter DATA_W, default 8, payload byte width.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 soft_reset  input  1  per-port timeout flush from router_sync, active-low (1 = normal, 0 = flush).
REQ-006 write_enb  input  1  one bit of router_sync write_enb[2:0]; write request.
REQ-007 read_enb  input  1  read request from output-port consumer.
REQ-008 lfd_state  input  1  marks data_in as packet header byte.
REQ-009 data_in  input  DATA_W  byte to store.
REQ-010 data_out  output  DATA_W  registered read data.
REQ-011 full  output  1  DEPTH words held.
REQ-012 empty  output  1  zero words held.

Function
REQ-013 Storage SHALL be DEPTH words of DATA_W+1 bits: {lfd_state, data_in}.
REQ-014 Pointers SHALL be log2(DEPTH)+1 bits wide; the MSB is the wrap bit; increments wrap modulo 2*DEPTH.
REQ-015 empty SHALL be 1 when wr_ptr == rd_ptr; full SHALL be 1 when the MSBs differ and the lower bits are equal; both are combinational from the pointers.
REQ-016 A write SHALL occur when write_enb=1 and full=0, storing the word at wr_ptr and incrementing wr_ptr.
REQ-017 A read SHALL occur when read_enb=1 and empty=0; data_out SHALL present the word's DATA_W bits one cycle later (1-cycle latency) and rd_ptr increments.
REQ-018 Write when full and read when empty SHALL be ignored with no state change.
REQ-019 Simultaneous read and write, neither blocked, SHALL both occur; occupancy is unchanged.
REQ-020 Simultaneous read and write when full: the read SHALL occur and the write SHALL be dropped (full evaluated pre-edge).
REQ-021 Simultaneous read and write when empty: the write SHALL occur and the read SHALL be ignored.
REQ-022 On reading a word with lfd bit 1, an internal 7-bit packet counter SHALL load data[7:2]+1 (payload length plus parity byte).
REQ-023 Each subsequent non-header read SHALL decrement the counter, saturating at 0.
REQ-024 When the counter is 0 and no read occurs, data_out SHALL be driven to 0 on the next edge; otherwise data_out holds its last value.

Reset
REQ-025 resetn=0 at an edge SHALL clear both pointers, the counter, and data_out to 0; full=0 and empty=1 the following cycle; storage contents need not clear.
REQ-026 soft_reset=0 at an edge (resetn=1) SHALL apply the same clears as REQ-025, overriding any read or write in that cycle.
REQ-027 resetn SHALL take priority over soft_reset; reset mid-packet SHALL discard the packet with no residual counter state.

Configuration
REQ-028 Macro ROUTER_FIFO_OVF_FLAG_EN defined: an extra 1-bit output overflow SHALL go to 1 one cycle after any write_enb=1 while full=1, sticky until resetn=0 or soft_reset=0.
REQ-029 Macro undefined: the overflow port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package router_pkg SHALL hold DATA_W, DEPTH, PTR_W=$clog2(DEPTH)+1, LEN_W=7, and the header length field position [7:2].
REQ-031 Sub-module router_fifo_mem (synchronous-write and synchronous-read register array, DEPTH x (DATA_W+1)) is natural; pointers, flags and the counter SHALL stay in router_fifo.

Verification
REQ-032 After reset: write 16 bytes 0x01..0x10 -> full=1 after the 16th write; a 17th write of 0xFF is dropped; read 16 -> data_out 0x01..0x10 in order, each 1 cycle after its read_enb; empty=1 after the last read.
REQ-033 Header 0x0C (lfd=1, len 3) plus 4 bytes; read all -> counter 4,3,2,1,0 across the reads; data_out=0x00 on the cycle after the final byte with read_enb=0.
REQ-034 Holding full: read_enb=1 and write_enb=1 with data_in=0xAA -> one word leaves, 0xAA is not stored, full deasserts.
REQ-035 Holding empty: read_enb=1 and write_enb=1 with data_in=0x55 -> empty deasserts, data_out unchanged; the next read returns 0x55.
REQ-036 Holding 5 words mid-packet: soft_reset=0 for 1 cycle -> empty=1, data_out=0, counter=0 next cycle; a following write/read of 0x33 returns 0x33.
REQ-037 ROUTER_FIFO_OVF_FLAG_EN build: write while full -> overflow=1 next cycle and stays 1 until soft_reset=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and header decode helper for the router output FIFO.
package router_pkg;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 16;
    localparam int PTR_W       = $clog2(DEPTH) + 1;
    localparam int LEN_W       = 7;
    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 2;

    // Bytes still to come after a header: payload length plus the parity byte.
    function automatic logic [LEN_W-1:0] hdr_count(input logic [7:0] hdr);
        return {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]} + {{(LEN_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Write/read handshake bundle between router_sync/consumer (master) and the FIFO (slave).
interface router_fifo_if #(
    parameter int DATA_W = 8
);

    logic              write_enb;
    logic              read_enb;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty
    );

endinterface

// File: rtl/router_fifo_mem.sv
// DEPTH x WORD_W storage array: synchronous write, read word presented for the current read pointer.
module router_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int WORD_W = 9,
    parameter int AW     = 4
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_word
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset; pointers define what is valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_word = mem_q[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// Router output-port FIFO with header-driven packet counter and idle data_out clearing.
// Optional sticky overflow output enabled by defining ROUTER_FIFO_OVF_FLAG_EN.
module router_fifo #(
    parameter int DEPTH  = router_pkg::DEPTH,
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          soft_reset,
    router_fifo_if.slave  bus
`ifdef ROUTER_FIFO_OVF_FLAG_EN
    ,
    output logic          overflow
`endif
);

    import router_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0]    PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DATA_W:0]   rd_word_s;
    logic              full_s, empty_s, wr_fire_s, rd_fire_s;

    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_fire_s = bus.write_enb & ~full_s;
    assign rd_fire_s = bus.read_enb & ~empty_s;

    router_fifo_mem #(
        .DEPTH  (DEPTH),
        .WORD_W (DATA_W + 1),
        .AW     (AW)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_fire_s & soft_reset),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data ({bus.lfd_state, bus.data_in}),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_word (rd_word_s)
    );

    // Next-state for pointers, packet counter and output register; soft reset overrides traffic.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        if (!soft_reset) begin
            wr_ptr_d   = {PW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
            pkt_cnt_d  = {LEN_W{1'b0}};
            data_out_d = {DATA_W{1'b0}};
        end else begin
            if (wr_fire_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_fire_s) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                data_out_d = rd_word_s[DATA_W-1:0];
                if (rd_word_s[DATA_W]) begin
                    pkt_cnt_d = hdr_count(rd_word_s[7:0]);
                end else if (pkt_cnt_q != {LEN_W{1'b0}}) begin
                    pkt_cnt_d = pkt_cnt_q - CNT_ONE;
                end else begin
                    pkt_cnt_d = pkt_cnt_q;
                end
            end else if (pkt_cnt_q == {LEN_W{1'b0}}) begin
                data_out_d = {DATA_W{1'b0}};
            end else begin
                data_out_d = data_out_q;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            pkt_cnt_q  <= {LEN_W{1'b0}};
            data_out_q <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.full     = full_s;
    assign bus.empty    = empty_s;

`ifdef ROUTER_FIFO_OVF_FLAG_EN
    logic overflow_q, overflow_d;

    // Sticky flag: any write attempt while full, cleared only by a flush.
    always_comb begin
        overflow_d = overflow_q;
        if (!soft_reset) begin
            overflow_d = 1'b0;
        end else if (bus.write_enb && full_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Overflow register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios plus random traffic against a queue model.
module tb_router_fifo;

    localparam int DEPTH = 16;

    logic clock;
    logic resetn;
    logic soft_reset;
`ifdef ROUTER_FIFO_OVF_FLAG_EN
    logic overflow;
`endif

    int checks = 0;
    int errors = 0;

    logic [8:0] mq [$];
    logic [6:0] m_cnt;
    logic [7:0] m_dout;
    logic       m_ovf;

    router_fifo_if #(.DATA_W(8)) bus ();

    router_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .bus        (bus)
`ifdef ROUTER_FIFO_OVF_FLAG_EN
        ,
        .overflow   (overflow)
`endif
    );

    always #5 clock = ~clock;

    // One clock: drive inputs, advance the reference queue model at the edge, settle.
    task automatic step(input logic we, input logic re, input logic lfd,
                        input logic [7:0] din, input logic srst, input logic rst);
        logic [8:0] w;
        bit do_rd, do_wr;
        bus.write_enb = we;
        bus.read_enb  = re;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        soft_reset    = srst;
        resetn        = rst;
        @(posedge clock);
        if (!rst || !srst) begin
            mq.delete();
            m_cnt  = 7'd0;
            m_dout = 8'h00;
            m_ovf  = 1'b0;
        end else begin
            do_rd = re && (mq.size() != 0);
            do_wr = we && (mq.size() != DEPTH);
            if (we && mq.size() == DEPTH) m_ovf = 1'b1;
            if (do_rd) begin
                w = mq.pop_front();
                m_dout = w[7:0];
                if (w[8]) m_cnt = {1'b0, w[7:2]} + 7'd1;
                else if (m_cnt != 7'd0) m_cnt = m_cnt - 7'd1;
            end else if (m_cnt == 7'd0) begin
                m_dout = 8'h00;
            end
            if (do_wr) mq.push_back({lfd, din});
        end
        #1;
    endtask

    task automatic wr(input logic [7:0] din, input logic lfd);
        step(1'b1, 1'b0, lfd, din, 1'b1, 1'b1);
    endtask

    task automatic rd();
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) wr(8'(i + 8'h40), 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
        checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", bus.data_out); end
        checks++; if (dut.pkt_cnt_q !== 7'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", dut.pkt_cnt_q); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL fill_early_full: write %0d got %b want 0", i, bus.full); end
            wr(8'(i), 1'b0);
        end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", bus.full); end
        wr(8'hFF, 1'b0);
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_drop_full: got %b want 1", bus.full); end
        for (int i = 1; i <= 16; i++) begin
            rd();
            checks++; if (bus.data_out !== 8'(i)) begin errors++; $display("FAIL drain_data: read %0d got %h want %h", i, bus.data_out, 8'(i)); end
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_packet();
        logic [7:0] pl [4];
        do_reset();
        wr(8'h0C, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pl[i] = 8'($urandom_range(1, 255));
            wr(pl[i], 1'b0);
        end
        rd();
        checks++; if (bus.data_out !== 8'h0C) begin errors++; $display("FAIL pkt_hdr: got %h want 0c", bus.data_out); end
        checks++; if (dut.pkt_cnt_q !== 7'd4) begin errors++; $display("FAIL pkt_cnt_hdr: got %0d want 4", dut.pkt_cnt_q); end
        for (int i = 0; i < 4; i++) begin
            rd();
            checks++; if (bus.data_out !== pl[i]) begin errors++; $display("FAIL pkt_data: byte %0d got %h want %h", i, bus.data_out, pl[i]); end
            checks++; if (dut.pkt_cnt_q !== 7'(3 - i)) begin errors++; $display("FAIL pkt_cnt: byte %0d got %0d want %0d", i, dut.pkt_cnt_q, 3 - i); end
        end
        idle();
        checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL pkt_idle_zero: got %h want 00", bus.data_out); end
    endtask

    task automatic test_full_rw();
        logic [7:0] b [16];
        do_reset();
        for (int i = 0; i < 16; i++) begin
            b[i] = 8'($urandom_range(0, 170));
            wr(b[i], 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b1);
        checks++; if (bus.data_out !== b[0]) begin errors++; $display("FAIL full_rw_data: got %h want %h", bus.data_out, b[0]); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL full_rw_full: got %b want 0", bus.full); end
        for (int i = 1; i < 16; i++) begin
            rd();
            checks++; if (bus.data_out !== b[i]) begin errors++; $display("FAIL full_rw_drain: word %0d got %h want %h", i, bus.data_out, b[i]); end
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_rw_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_empty_rw();
        do_reset();
        idle();
        step(1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL empty_rw_empty: got %b want 0", bus.empty); end
        checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL empty_rw_dout: got %h want 00", bus.data_out); end
        rd();
        checks++; if (bus.data_out !== 8'h55) begin errors++; $display("FAIL empty_rw_read: got %h want 55", bus.data_out); end
    endtask

    task automatic test_soft_reset();
        do_reset();
        wr(8'h14, 1'b1);
        for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i), 1'b0);
        rd();
        checks++; if (dut.pkt_cnt_q !== 7'd6) begin errors++; $display("FAIL srst_pre_cnt: got %0d want 6", dut.pkt_cnt_q); end
        step(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL srst_empty: got %b want 1", bus.empty); end
        checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL srst_dout: got %h want 00", bus.data_out); end
        checks++; if (dut.pkt_cnt_q !== 7'd0) begin errors++; $display("FAIL srst_cnt: got %0d want 0", dut.pkt_cnt_q); end
        wr(8'h33, 1'b0);
        rd();
        checks++; if (bus.data_out !== 8'h33) begin errors++; $display("FAIL srst_after: got %h want 33", bus.data_out); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL srst_after_empty: got %b want 1", bus.empty); end
    endtask

`ifdef ROUTER_FIFO_OVF_FLAG_EN
    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b want 0", overflow); end
        wr(8'h99, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        rd(); rd(); idle();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask
`endif

    task automatic test_random();
        logic we, re, lfd, srst, rst;
        logic exp_e, exp_f;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            we   = ($urandom_range(0, 99) < 55);
            re   = ($urandom_range(0, 99) < 45);
            lfd  = ($urandom_range(0, 7) == 0);
            srst = ($urandom_range(0, 199) != 0);
            rst  = ($urandom_range(0, 499) != 0);
            step(we, re, lfd, 8'($urandom), srst, rst);
            exp_e = (mq.size() == 0);
            exp_f = (mq.size() == DEPTH);
            checks++; if (bus.empty !== exp_e) begin errors++; $display("FAIL rnd_empty: cycle %0d got %b want %b", n, bus.empty, exp_e); end
            checks++; if (bus.full !== exp_f) begin errors++; $display("FAIL rnd_full: cycle %0d got %b want %b", n, bus.full, exp_f); end
            checks++; if (bus.data_out !== m_dout) begin errors++; $display("FAIL rnd_dout: cycle %0d got %h want %h", n, bus.data_out, m_dout); end
            checks++; if (dut.pkt_cnt_q !== m_cnt) begin errors++; $display("FAIL rnd_cnt: cycle %0d got %0d want %0d", n, dut.pkt_cnt_q, m_cnt); end
`ifdef ROUTER_FIFO_OVF_FLAG_EN
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf: cycle %0d got %b want %b", n, overflow, m_ovf); end
`endif
        end
    endtask

    initial begin
        clock         = 1'b0;
        resetn        = 1'b0;
        soft_reset    = 1'b1;
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = 8'h00;
        m_cnt         = 7'd0;
        m_dout        = 8'h00;
        m_ovf         = 1'b0;
        do_reset();
        do_reset();
        test_reset();
        test_fill_drain();
        test_packet();
        test_full_rw();
        test_empty_rw();
        test_soft_reset();
`ifdef ROUTER_FIFO_OVF_FLAG_EN
        test_overflow();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
